// File: rtl/ascon_block_padder.sv
// Ascon block padder: fetches 64-bit message words by index, applies 10* rate padding and emits rate blocks.
// Latency: RD_LAT+2 cycles per data block with blk_ready held high, and 1 cycle for a padding-only block.
// Backpressure: the block is held stable in OUT until blk_valid && blk_ready. Optional macro PAD_BYPASS_EN adds the pad_en input.
module ascon_block_padder #(
    parameter int RD_LAT = 1,
    parameter int LEN_W  = 7
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] datalen,
`ifdef PAD_BYPASS_EN
    input  logic             pad_en,
`endif
    output logic             rd_req,
    output logic [3:0]       rd_idx,
    input  logic [63:0]      rd_data,
    output logic [63:0]      blk_data,
    output logic [3:0]       blk_bytes,
    output logic             blk_last,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [3:0]       idx_q, idx_d;
    logic [1:0]       lat_q, lat_d;
    logic [63:0]      blk_data_q, blk_data_d;
    logic [3:0]       blk_bytes_q, blk_bytes_d;
    logic             blk_last_q, blk_last_d;

    // Padding select: taken live from the input while idle, from the latched copy otherwise.
    logic             pad_sel;
`ifdef PAD_BYPASS_EN
    logic             pad_q, pad_d;
    assign pad_sel = (state_q == S_IDLE) ? pad_en : pad_q;
`else
    assign pad_sel = 1'b1;
`endif

    // Remaining count after the current full block has been consumed.
    logic [LEN_W-1:0] rem_after;
    assign rem_after = rem_q - LEN_W'(8);

    // Block formation inputs: the word being captured and the byte count it covers.
    logic [LEN_W-1:0] fm_rem;
    logic [63:0]      fm_word;
    logic [3:0]       fm_n;
    logic [63:0]      fm_data;
    logic             fm_last;

    // Select what the block former looks at in each state.
    always_comb begin
        fm_word = '0;
        fm_rem  = rem_q;
        case (state_q)
            S_IDLE:  fm_rem = datalen;
            S_WAIT:  fm_word = rd_data;
            S_OUT:   fm_rem = rem_after;
            default: fm_rem = rem_q;
        endcase
    end

    // Keep the top n bytes, place 0x80 at byte n (when padding), zero everything below.
    always_comb begin
        fm_n    = (fm_rem >= LEN_W'(8)) ? 4'd8 : fm_rem[3:0];
        fm_last = pad_sel ? (fm_rem < LEN_W'(8)) : (fm_rem <= LEN_W'(8));
        fm_data = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < fm_n) begin
                fm_data[63-8*b -: 8] = fm_word[63-8*b -: 8];
            end else if ((4'(b) == fm_n) && pad_sel) begin
                fm_data[63-8*b -: 8] = 8'h80;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. rem==0 in WAIT only happens for an unpadded empty message.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (datalen != '0) state_d = S_REQ;
                    else if (pad_sel)  state_d = S_OUT;
                    else               state_d = S_WAIT;
                end
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (rem_q == '0)                      state_d = S_DONE;
                else if (lat_q == 2'(RD_LAT - 1))    state_d = S_OUT;
            end
            S_OUT: begin
                if (blk_ready) begin
                    if (blk_last_q)              state_d = S_DONE;
                    else if (rem_after != '0)    state_d = S_REQ;
                    else                         state_d = S_OUT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from state.
    always_comb begin
        rd_req    = (state_q == S_REQ);
        blk_valid = (state_q == S_OUT);
        busy      = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_OUT);
        done      = (state_q == S_DONE);
    end

    assign rd_idx    = idx_q;
    assign blk_data  = blk_data_q;
    assign blk_bytes = blk_bytes_q;
    assign blk_last  = blk_last_q;

    // Datapath next-state: length/index bookkeeping, latency count and block capture.
    always_comb begin
        rem_d       = rem_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        blk_data_d  = blk_data_q;
        blk_bytes_d = blk_bytes_q;
        blk_last_d  = blk_last_q;
`ifdef PAD_BYPASS_EN
        pad_d       = pad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d = datalen;
                    idx_d = '0;
                    lat_d = '0;
`ifdef PAD_BYPASS_EN
                    pad_d = pad_en;
`endif
                    if (datalen == '0) begin
                        blk_data_d  = fm_data;
                        blk_bytes_d = fm_n;
                        blk_last_d  = fm_last;
                    end
                end
            end
            S_REQ: lat_d = '0;
            S_WAIT: begin
                if (rem_q != '0) begin
                    if (lat_q == 2'(RD_LAT - 1)) begin
                        blk_data_d  = fm_data;
                        blk_bytes_d = fm_n;
                        blk_last_d  = fm_last;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
            end
            S_OUT: begin
                if (blk_ready && !blk_last_q) begin
                    rem_d = rem_after;
                    idx_d = idx_q + 4'd1;
                    if (rem_after == '0) begin
                        blk_data_d  = fm_data;
                        blk_bytes_d = fm_n;
                        blk_last_d  = fm_last;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rem_q       <= '0;
            idx_q       <= '0;
            lat_q       <= '0;
            blk_data_q  <= '0;
            blk_bytes_q <= '0;
            blk_last_q  <= 1'b0;
`ifdef PAD_BYPASS_EN
            pad_q       <= 1'b1;
`endif
        end else begin
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            blk_data_q  <= blk_data_d;
            blk_bytes_q <= blk_bytes_d;
            blk_last_q  <= blk_last_d;
`ifdef PAD_BYPASS_EN
            pad_q       <= pad_d;
`endif
        end
    end

endmodule

// File: doc/ascon_block_padder.md
Name: ascon_block_padder

Overview:
- Downstream consumer of the message buffer: fetches 64-bit words by block index, applies the Ascon 10* rate padding and presents rate-sized blocks to the permutation/absorb core over a valid/ready handshake.
- Tracks the remaining byte count from a 7-bit message length.
- Generates the final padded block, including the padding-only block when the length is a multiple of 8.

Parameters:
RD_LAT, 1, buffer read latency in cycles from rd_req to rd_data valid (legal 1..3)
LEN_W, 7, width of the byte-length input

Ports:
clk  input  1  system clock
RST  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse, begin a message; sampled only in IDLE
datalen  input  LEN_W  message length in bytes (0..127), captured on accepted start
rd_req  output  1  one-cycle buffer read strobe
rd_idx  output  4  64-bit word index being read (0..15)
rd_data  input  64  buffer word, valid RD_LAT cycles after rd_req; byte 0 in bits [63:56]
blk_data  output  64  padded rate block
blk_bytes  output  4  count of real message bytes in blk_data (0..8)
blk_last  output  1  block is the final (padded) block
blk_valid  output  1  block available
blk_ready  input  1  core accepts block when blk_valid && blk_ready
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the last block handshake

Behaviour:
- Reset (async, RST=1): state IDLE. rd_req, rd_idx, blk_data, blk_bytes, blk_last, blk_valid, busy and done are all 0. Remaining count and latency counter cleared.
- Reset mid-message abandons the message; no done pulse is generated.
- States: IDLE, REQ, WAIT, OUT, DONE.
- IDLE:
  - start=1 latches rem=datalen and idx=0, sets busy.
  - If rem>0, go to REQ. If rem==0, go to OUT with a padding-only block and no read.
- REQ: rd_req=1 for exactly one cycle with rd_idx=idx, then go to WAIT.
- WAIT: counts RD_LAT-1 cycles, then captures rd_data into the block register. With RD_LAT=1, capture occurs the cycle after REQ.
- Block formation, with n=min(rem,8):
  - n==8: blk_data=rd_data, blk_bytes=8. blk_last=1 only when PAD_BYPASS_EN is active and bypass is selected (see Optional Feature); otherwise 0.
  - n<8: keep the top 8n bits of rd_data, set byte n to 0x80, zero all lower bytes. blk_bytes=n, blk_last=1.
  - rem==0 padding-only block: blk_data=64'h8000_0000_0000_0000, blk_bytes=0, blk_last=1.
- OUT:
  - blk_valid=1. blk_data, blk_bytes and blk_last are held stable until the handshake; backpressure of any length is legal.
  - On handshake, if blk_last: go to DONE.
  - Otherwise rem-=8 and idx+=1. If the new rem>0, go to REQ; if rem==0, form the padding-only block and stay in OUT (no read).
- DONE: done=1 for one cycle, busy cleared, go to IDLE. blk_valid drops on the cycle after the handshake.
- Block count = floor(datalen/8)+1, at most 16. rd_idx never exceeds 15; no wrap.
- rd_req is issued only for indices holding at least 1 real byte.
- start while busy is ignored. datalen changes after capture have no effect.
- Throughput: one block per RD_LAT+2 cycles with blk_ready held high; the padding-only block takes one cycle.

Optional Feature:
- Macro: PAD_BYPASS_EN.
- Defined: adds input port pad_en (1 bit), captured on start.
  - pad_en=0: no 0x80 byte; partial blocks are zero-filled below the data bytes.
  - pad_en=0: no padding-only block is generated. The block containing the last byte carries blk_last=1, even when full.
  - pad_en=0 and datalen=0: no blocks are emitted; done pulses 2 cycles after start.
  - pad_en=1: identical to the undefined case.
- Undefined: no pad_en port; padding is always applied.

Test Plan:
- datalen=0, start -> no rd_req; one block 64'h8000000000000000 with blk_bytes=0, blk_last=1; done one cycle after the handshake.
- datalen=3, rd_data=64'h1122334455667788 -> rd_idx=0; blk_data=64'h1122338000000000, blk_bytes=3, blk_last=1.
- datalen=8, rd_data=64'hA5A5A5A5A5A5A5A5 -> block0 is the raw word with blk_bytes=8, blk_last=0; block1 is 64'h8000000000000000 with blk_last=1; exactly one rd_req.
- datalen=127, blk_ready always 1 -> 16 blocks, rd_idx 0..15; last block blk_bytes=7 with byte 7 = 0x80; busy high throughout.
- datalen=20, blk_ready held low 10 cycles on block1 -> blk_data stable; no extra rd_req; sequence 8, 8, 4 bytes completes unchanged. start pulsed mid-run is ignored.
- RST asserted while in WAIT -> all outputs 0 immediately. The next start with datalen=5 behaves as after a clean reset.
